// File: rtl/hex_scroll_ctrl.sv
// Stores a message of seven-segment glyphs and scrolls it right-to-left across hex0..hex7.
// Latency: glyph captured on the accepting edge; busy/blanking one edge after start; step every TICK_DIV edges.
// Backpressure: wr_ready low while scrolling or once a full MSG_DEPTH message sits unconsumed in the buffer.
module hex_scroll_ctrl #(
    parameter int         TICK_DIV  = 50_000_000,
    parameter int         MSG_DEPTH = 16,
    parameter int         GAP       = 3,
    parameter logic [6:0] BLANK     = 7'b1111111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [6:0] wr_seg,
    input  logic       wr_last,
    input  logic       start,
    input  logic       pause,
    input  logic       stop,
    output logic       busy,
    output logic       step,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5,
    output logic [6:0] hex6,
    output logic [6:0] hex7
);

    localparam int LW = $clog2(MSG_DEPTH + 1);
    localparam int PW = $clog2(MSG_DEPTH + GAP + 1);
    localparam int IW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
    localparam int TW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SCROLL = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [6:0]  mem [MSG_DEPTH];
    logic [LW-1:0] len, cnt;
    logic [PW-1:0] pos, pos_inc, period;
    logic [TW-1:0] tick;
    logic [6:0]  disp [8];

    logic xfer, start_go, load_done, tick_wrap, step_fire;
    logic [6:0] stream_glyph;

    // cnt is cleared when scrolling starts, so a full message only blocks new
    // writes until it has been consumed (scrolled) once.
    assign wr_ready  = (state != SCROLL) && (cnt < LW'(MSG_DEPTH));
    assign xfer      = wr_valid && wr_ready;
    assign start_go  = (state == IDLE) && start && (len != '0) && !xfer;
    assign load_done = wr_last || ((cnt + LW'(1)) == LW'(MSG_DEPTH));
    assign tick_wrap = (state == SCROLL) && !pause && (tick == TW'(TICK_DIV - 1));
    assign step_fire = tick_wrap && !stop;
    assign busy      = (state == SCROLL);

    assign period       = PW'(len) + PW'(GAP);
    assign pos_inc      = pos + PW'(1);
    assign stream_glyph = (pos < PW'(len)) ? mem[pos[IW-1:0]] : BLANK;

    assign hex0 = disp[0];
    assign hex1 = disp[1];
    assign hex2 = disp[2];
    assign hex3 = disp[3];
    assign hex4 = disp[4];
    assign hex5 = disp[5];
    assign hex6 = disp[6];
    assign hex7 = disp[7];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: writes take priority over start; stop always wins in SCROLL.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (xfer)          state_nxt = load_done ? IDLE : LOAD;
                else if (start_go) state_nxt = SCROLL;
            end
            LOAD: begin
                if (xfer && load_done) state_nxt = IDLE;
            end
            SCROLL: begin
                if (stop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Glyph storage: no reset, contents only matter below len.
    always_ff @(posedge clk) begin
        if (xfer) mem[(state == IDLE) ? '0 : cnt[IW-1:0]] <= wr_seg;
    end

    // Message length/count bookkeeping; a write in IDLE discards the old message.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            len <= '0;
        end else if (xfer) begin
            if (state == IDLE) begin
                cnt <= LW'(1);
                len <= load_done ? LW'(1) : '0;
            end else begin
                cnt <= cnt + LW'(1);
                if (load_done) len <= cnt + LW'(1);
            end
        end else if (start_go) begin
            cnt <= '0;
        end
    end

    // Step timer, stream position and display shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick <= '0;
            pos  <= '0;
            step <= 1'b0;
            for (int i = 0; i < 8; i++) disp[i] <= BLANK;
        end else begin
            step <= step_fire;
            if (start_go) begin
                tick <= '0;
                pos  <= '0;
                for (int i = 0; i < 8; i++) disp[i] <= BLANK;
            end else if (state == SCROLL) begin
                if (stop) begin
                    tick <= '0;
                    for (int i = 0; i < 8; i++) disp[i] <= BLANK;
                end else if (!pause) begin
                    if (tick_wrap) begin
                        tick <= '0;
                        pos  <= (pos_inc == period) ? '0 : pos_inc;
                        for (int i = 7; i > 0; i--) disp[i] <= disp[i-1];
                        disp[0] <= stream_glyph;
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: doc/hex_scroll_ctrl.md
# hex_scroll_ctrl

Message scheduler for the 8-digit seven-segment bank. It accepts a message of raw segment glyphs over a valid/ready write port and stores up to MSG_DEPTH glyphs. On command it scrolls the message right-to-left across hex0..hex7 at a programmable step rate, with pause/stop control. It replaces per-message hand-written scroll sequences and sits between any glyph producer and the hex pins.

## Interface
- TICK_DIV, 50_000_000: clk cycles per scroll step (≥2).
- MSG_DEPTH, 16: max glyphs stored.
- GAP, 3: blank glyphs inserted after the message before wrap (≥0).
- BLANK, 7'b1111111: glyph for an unlit digit (segments active-low, 0 = lit).
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  glyph write request.
- wr_ready  out  1  block can accept a glyph.
- wr_seg  in  7  glyph segment pattern, active-low.
- wr_last  in  1  marks final glyph of message (qualified by wr_valid).
- start  in  1  begin scrolling (level sampled per cycle).
- pause  in  1  freeze step timer while high.
- stop  in  1  abort scrolling, return to IDLE.
- busy  out  1  high in SCROLL.
- step  out  1  one-cycle pulse coinciding with each display shift.
- hex0..hex7  out  7 each  digit segments; hex0 rightmost (entry), hex7 leftmost.

## Operation
- States: IDLE, LOAD, SCROLL. Reset → IDLE.
- Glyph buffer MSG_DEPTH×7; length register len, width clog2(MSG_DEPTH+1).
- wr_ready = 1 in IDLE and in LOAD while cnt < MSG_DEPTH; 0 in SCROLL. Combinational from state/cnt.
- Transfer = wr_valid & wr_ready.
- IDLE + transfer: old message discarded, glyph stored at index 0, cnt=1; → LOAD, or stays IDLE with len=1 if wr_last.
- LOAD + transfer: glyph stored at index cnt, cnt+1. On wr_last, or on the transfer that makes cnt = MSG_DEPTH: len = final count, → IDLE.
- start in IDLE with len>0 and no transfer same cycle: → SCROLL. All hex set to BLANK, pos=0, tick counter=0. Ignored in LOAD, in SCROLL, when len=0, or coincident with a transfer (write wins).
- Stream: period P = len+GAP. stream[k] = glyph[k] for k<len, BLANK otherwise.
- SCROLL step: tick counter counts 0..TICK_DIV-1 while pause=0. At TICK_DIV-1 it returns to 0 and a step fires: hex7←hex6 … hex1←hex0, hex0←stream[pos], pos←(pos+1) mod P, step=1.
- pause=1: counter holds, no steps, display frozen. Release resumes from held count.
- stop in SCROLL: → IDLE next edge, all hex←BLANK, message retained. stop beats a same-cycle step. stop outside SCROLL has no effect.
- IDLE/LOAD: hex holds last value (BLANK after reset or stop).

## Timing
- Reset values: hex0..hex7=BLANK, busy=0, step=0, len=0, cnt=0, pos=0, tick=0. wr_ready=1 (IDLE) as soon as rst_n releases.
- Reset mid-operation: immediate return to reset values; buffer contents don't-care; len=0.
- Write acceptance: zero latency, glyph captured on the edge where transfer is high.
- start → busy high and hex blanked on the next edge.
- First step fires TICK_DIV edges after the start edge; subsequent steps every TICK_DIV edges (excluding paused cycles).
- step and hex update are registered on the same edge.
- After n steps (n ≤ 8): hex(n-1-i) = stream[i] for i<n, remaining digits BLANK.

## Test plan
- Reset: assert rst_n=0 mid-cycle → all hex=7'b1111111, busy=0, step=0, wr_ready=1, asynchronously.
- HELLO, TICK_DIV=4, GAP=3: write H=0001001, E=0000110, L=1000111, L, O=1000000 (wr_last on O), then start. After step 5: hex4..hex0 = H,E,L,L,O, hex7..5 blank. After step 8: hex7..hex3 = H,E,L,L,O, hex2..0 blank. After step 9: hex7=E, hex0=H (wrap). Steps spaced exactly 4 cycles.
- Overflow: 16 writes without wr_last → wr_ready=0 in the cycle after the 16th, state IDLE, len=16. A 17th wr_valid is not accepted.
- Pause/stop: pause for 10 cycles mid-scroll → no step, hex frozen, next step 4−held count cycles after release. stop coincident with a step edge → no shift, all hex BLANK, busy=0 next cycle.
- Collisions: start with wr_valid in IDLE → glyph accepted, state not SCROLL. start with len=0 → stays IDLE. wr_valid in SCROLL → wr_ready=0, buffer unchanged.
- Reset mid-scroll at step 6 → outputs return to reset values. start after release is ignored (len=0).
